// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage of the 8-bit teaching CPU. Holds the program counter, issues
//   one instruction-memory request per fetch with a ready handshake, latches
//   the returned byte into the instruction register, and selects the next pc
//   from the external jump decoder result (jump target or pc+1).
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   mem_req      out  fetch request to instruction memory (registered)
//   mem_addr     out  fetch address, equal to pc
//   mem_ready    in   mem_data valid this cycle (only looked at while in REQ)
//   mem_data     in   instruction byte from memory
//   instruction  out  instruction register, feeds the jump decoder
//   jump         in   decoder result for the current instruction
//   stall        in   downstream not ready, holds DECODE
//   instr_valid  out  high in every DECODE cycle (registered)
//   pc           out  address being fetched or decoded
//   jump_count   out  taken jumps since reset, saturates at 255
module instr_fetch_unit #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] instruction,
    input  logic               jump,
    input  logic               stall,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [7:0]         jump_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        DECODE = 2'd2
    } state_t;

    state_t state;

    // pc only changes on the edge leaving DECODE, so it is already the
    // request address on the first REQ cycle.
    assign mem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            instruction <= '0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            jump_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= REQ;
                    mem_req <= 1'b1;
                end

                REQ: begin
                    if (mem_ready) begin
                        instruction <= mem_data;
                        state       <= DECODE;
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end

                DECODE: begin
                    if (!stall) begin
                        state       <= REQ;
                        mem_req     <= 1'b1;
                        instr_valid <= 1'b0;
                        if (jump) begin
                            pc <= instruction[ADDR_W-1:0];
                            if (jump_count != 8'hFF) begin
                                jump_count <= jump_count + 8'd1;
                            end
                        end else begin
                            pc <= pc + ADDR_W'(1);
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed and randomized bench for instr_fetch_unit. A behavioural memory
//   and a transaction-level model (one fetch = address, byte, next pc rule)
//   provide every expected value.
module tb_instr_fetch_unit;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 8;
    localparam int DEPTH   = 1 << ADDR_W;

    logic               clk;
    logic               reset;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ready;
    logic [INSTR_W-1:0] mem_data;
    logic [INSTR_W-1:0] instruction;
    logic               jump;
    logic               stall;
    logic               instr_valid;
    logic [ADDR_W-1:0]  pc;
    logic [7:0]         jump_count;

    int checks   = 0;
    int failures = 0;

    logic [INSTR_W-1:0] memory [DEPTH];

    // model state
    logic [ADDR_W-1:0]  model_pc;
    logic [INSTR_W-1:0] model_ir;
    int                 model_jc;
    logic               noise_bit;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data),
        .instruction (instruction),
        .jump        (jump),
        .stall       (stall),
        .instr_valid (instr_valid),
        .pc          (pc),
        .jump_count  (jump_count)
    );

    // Jump decoder: opcode bits 11 mean jump. Outside DECODE the decoder
    // output is replaced by noise, which the DUT must ignore.
    function automatic logic is_jump(input logic [INSTR_W-1:0] ins);
        return ins[INSTR_W-1 -: 2] == 2'b11;
    endfunction

    assign jump = instr_valid ? is_jump(instruction) : noise_bit;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        noise_bit = 1'($urandom);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        stall     = 1'b0;
        tick();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_instruction", 32'(instruction), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_jump_count", 32'(jump_count), 0);
        model_pc = '0;
        model_ir = '0;
        model_jc = 0;
    endtask

    // Release reset and spend the single IDLE cycle.
    task automatic release_reset();
        reset = 1'b0;
        check("idle_no_req", 32'(mem_req), 0);
        tick();
        check("first_req", 32'(mem_req), 1);
        check("first_addr", 32'(mem_addr), 0);
    endtask

    // One full fetch transaction starting in the first REQ cycle.
    task automatic fetch_one(input int waits, input int stalls);
        logic [INSTR_W-1:0] byte_v;
        check("req_high", 32'(mem_req), 1);
        check("req_addr", 32'(mem_addr), 32'(model_pc));
        check("req_not_valid", 32'(instr_valid), 0);
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            mem_data  = INSTR_W'($urandom);
            stall     = 1'($urandom);
            tick();
            check("wait_req", 32'(mem_req), 1);
            check("wait_addr", 32'(mem_addr), 32'(model_pc));
            check("wait_not_valid", 32'(instr_valid), 0);
            check("wait_ir_hold", 32'(instruction), 32'(model_ir));
        end
        byte_v    = memory[model_pc];
        mem_ready = 1'b1;
        mem_data  = byte_v;
        stall     = 1'($urandom);
        tick();
        model_ir  = byte_v;
        mem_ready = 1'($urandom);
        mem_data  = INSTR_W'($urandom);
        check("cap_valid", 32'(instr_valid), 1);
        check("cap_no_req", 32'(mem_req), 0);
        check("cap_ir", 32'(instruction), 32'(model_ir));
        for (int j = 0; j < stalls; j++) begin
            stall = 1'b1;
            tick();
            check("stall_valid", 32'(instr_valid), 1);
            check("stall_pc", 32'(pc), 32'(model_pc));
            check("stall_ir", 32'(instruction), 32'(model_ir));
            check("stall_jc", 32'(jump_count), 32'(model_jc));
        end
        stall = 1'b0;
        tick();
        if (is_jump(model_ir)) begin
            model_pc = model_ir[ADDR_W-1:0];
            if (model_jc < 255) model_jc++;
        end else begin
            model_pc = ADDR_W'((int'(model_pc) + 1) % DEPTH);
        end
        check("next_req", 32'(mem_req), 1);
        check("next_valid", 32'(instr_valid), 0);
        check("next_pc", 32'(pc), 32'(model_pc));
        check("next_jc", 32'(jump_count), 32'(model_jc));
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        mem_data  = '0;
        stall     = 1'b0;
        noise_bit = 1'b0;
        for (int i = 0; i < DEPTH; i++) memory[i] = '0;

        // Reset, then sequential fetch of zero bytes
        do_reset();
        release_reset();
        for (int a = 0; a < 4; a++) begin
            check("seq_addr", 32'(mem_addr), 32'(a));
            fetch_one(0, 0);
        end

        // Taken jump at address 2, then non-jumps 0x80 and 0x00
        memory[2] = 8'b1100_0101;
        memory[5] = 8'b1000_0000;
        memory[6] = 8'b0000_0000;
        memory[7] = 8'h3A;
        memory[8] = 8'b1100_0000;
        do_reset();
        release_reset();
        fetch_one(0, 0);
        fetch_one(0, 0);
        fetch_one(0, 0);
        check("jump_addr", 32'(mem_addr), 5);
        check("jump_count1", 32'(jump_count), 1);
        fetch_one(0, 0);
        check("nonjump80_addr", 32'(mem_addr), 6);
        fetch_one(0, 0);
        check("nonjump00_addr", 32'(mem_addr), 7);
        check("nonjump_jc", 32'(jump_count), 1);

        // Wait states at address 7
        fetch_one(3, 0);
        check("wait_capture", 32'(instruction), 32'h3A);
        check("after_wait_addr", 32'(mem_addr), 8);

        // Stall during a jump to 0
        fetch_one(0, 2);
        check("stall_jump_pc", 32'(pc), 0);
        check("stall_jump_jc", 32'(jump_count), 2);

        // Wrap: jump to 63, non-jump there goes to 0
        memory[0]  = 8'hFF;
        memory[63] = 8'b0000_0101;
        fetch_one(0, 0);
        check("to_63", 32'(mem_addr), 63);
        fetch_one(1, 0);
        check("wrap_addr", 32'(mem_addr), 0);
        check("wrap_jc", 32'(jump_count), 3);

        // Jump to self (target equal to pc)
        memory[0] = 8'hC0;
        fetch_one(0, 1);
        check("self_jump_addr", 32'(mem_addr), 0);
        memory[0] = 8'hFF;
        fetch_one(0, 0);
        check("pre_reset_pc", 32'(pc), 63);

        // Reset in the middle of REQ with pc=63
        mem_ready = 1'b0;
        do_reset();
        release_reset();

        // Random program, random waits, stalls and don't-care inputs
        for (int i = 0; i < DEPTH; i++) memory[i] = INSTR_W'($urandom);
        for (int n = 0; n < 150; n++) begin
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        // Reset during DECODE, then an all-jump program to reach saturation
        mem_ready = 1'b1;
        mem_data  = memory[mem_addr];
        tick();
        check("pre_decode_reset_valid", 32'(instr_valid), 1);
        do_reset();
        release_reset();
        for (int i = 0; i < DEPTH; i++) memory[i] = {2'b11, ADDR_W'($urandom)};
        for (int n = 0; n < 270; n++) begin
            fetch_one(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end
        check("jc_saturated", 32'(jump_count), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the 8-bit teaching CPU. It holds the program counter, requests one instruction per fetch from instruction memory with a ready handshake, and latches the returned byte into the instruction register. The register drives the `instruction` input of the downstream `isJumpInstruction` decoder. The decoder's `jump` result comes back into this block and selects the next PC: either the jump target or a sequential increment.

## Interface
- ADDR_W, 6: program counter and memory address width; the jump target field is instruction[ADDR_W-1:0].
- INSTR_W, 8: instruction width; must be ≥ ADDR_W+2.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  ADDR_W  fetch address; equals pc while mem_req is high.
- mem_ready  input  1  memory has mem_data valid this cycle; ignored while mem_req is low.
- mem_data  input  INSTR_W  instruction byte from memory.
- instruction  output  INSTR_W  instruction register; feeds isJumpInstruction.
- jump  input  1  decoder result for the current `instruction`; combinational from `instruction`.
- stall  input  1  downstream not ready; holds the current instruction in DECODE.
- instr_valid  output  1  high in every DECODE cycle; `instruction` is valid.
- pc  output  ADDR_W  address of the instruction currently being fetched or decoded.
- jump_count  output  8  number of taken jumps since reset; saturates at 255.

## Operation
- State machine states: IDLE, REQ, DECODE.
- IDLE: entered only by reset. Always goes to REQ on the next edge.
- REQ:
  - mem_req=1 and mem_addr=pc.
  - On an edge with mem_ready=1: IR <= mem_data, go to DECODE.
  - Otherwise stay in REQ; pc and IR hold.
- DECODE:
  - instr_valid=1 and mem_req=0.
  - stall=1: stay in DECODE; IR and pc hold; jump is not acted on.
  - stall=0 and jump=1: pc <= instruction[ADDR_W-1:0], jump_count increments (saturating at 255), go to REQ.
  - stall=0 and jump=0: pc <= pc+1, modulo 2^ADDR_W, go to REQ.
- jump is sampled only on the edge that leaves DECODE; its value in other states has no effect.
- Wrap-around: pc=2^ADDR_W-1 with a non-jump goes to 0.
- A jump target equal to the current pc is legal: the same address is refetched.
- mem_data is not sampled unless the block is in REQ and mem_ready=1.

## Timing
- Reset values, after any edge with reset=1:
  - state=IDLE, pc=0, instruction=0, mem_req=0, mem_addr=0, instr_valid=0, jump_count=0.
- Reset mid-operation (in REQ or DECODE): the outstanding fetch is abandoned and mem_req drops after that edge.
- First request: mem_req rises one cycle after reset deasserts (IDLE lasts one cycle).
- mem_ready may be high in the first REQ cycle; the minimum REQ dwell is 1 cycle.
- Fetch-to-valid latency: instr_valid rises on the edge that samples mem_ready=1 and lasts exactly 1 cycle when stall=0.
- Throughput: at best one instruction per 2 cycles (REQ, DECODE) when mem_ready is always high and stall is always low.
- Next address: the new pc appears on mem_addr in the first REQ cycle after DECODE, with no bubble.
- All outputs are registered or decoded from the registered state only. There are no combinational paths from any input to mem_req or instr_valid.

## Test plan
- Reset, then sequential fetch: mem_ready held 1, memory returns 8'h00 at every address, stall=0.
  - Required: mem_addr sequence 0,1,2,3; instr_valid pulses every 2nd cycle; first request 1 cycle after reset release.
- Taken jump: the byte at address 2 is 8'b11000101, the decoder is connected, stall=0.
  - Required: after DECODE of address 2, next mem_addr=5; jump_count=1.
- Non-jump bytes 8'b10000000 and 8'b00000000: pc increments by 1 and jump_count is unchanged.
- Wait states: mem_ready low for 3 cycles in REQ.
  - Required: mem_req and mem_addr held stable for 4 cycles; IR captures only on the ready cycle.
- Stall during a jump: in DECODE with instruction 8'b11000000, hold stall=1 for 2 cycles, then release.
  - Required: instr_valid high for 3 cycles; pc unchanged until the release edge, then 0; only one jump counted.
- Wrap and mid-fetch reset:
  - pc=63 with non-jump byte 8'b00000101: next mem_addr=0.
  - reset asserted during REQ: next cycle mem_req=0, pc=0, instr_valid=0, jump_count=0.
